// File: rtl/bram_arb_ctrl.sv
// Multi-channel arbiter in front of a single-port block RAM with tagged, pipelined read return.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module bram_arb_ctrl #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 2,
   parameter int OUT_REG    = 0
) (
   input  logic                         clk,
   input  logic                         reset_l,
   input  logic [NUM_CH-1:0]            req,
   input  logic [NUM_CH-1:0]            rh_wl,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_w,
   output logic [NUM_CH-1:0]            ack,
   output logic [DATA_WIDTH-1:0]        data_r,
   output logic [NUM_CH-1:0]            data_r_en
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] w_ch_addr [NUM_CH];
   logic [DATA_WIDTH-1:0] w_ch_data [NUM_CH];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign w_ch_addr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_ch_data[gi] = data_w[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   logic [NUM_CH-1:0] w_grant;
   logic [IDX_W-1:0]  w_gidx;
   logic              w_any;

`ifdef BRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         if (req[k]) begin
            w_gidx = IDX_W'(k);
            w_any  = 1'b1;
         end
      end
      if (w_any) w_grant[w_gidx] = 1'b1;
   end
`else
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   w_cand;

   // Search starts at r_ptr and wraps; r_ptr is always < NUM_CH so one subtraction suffices.
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_cand >= (IDX_W+1)'(NUM_CH)) w_cand = w_cand - (IDX_W+1)'(NUM_CH);
         if (!w_any && req[w_cand[IDX_W-1:0]]) begin
            w_any  = 1'b1;
            w_gidx = w_cand[IDX_W-1:0];
         end
      end
      if (w_any) w_grant[w_gidx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_gidx == IDX_W'(NUM_CH-1)) ? '0 : w_gidx + 1'b1;
      end
   end
`endif

   logic                  w_fire;
   logic                  w_rd_fire;
   logic                  w_wr_fire;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_data;

   assign ack        = w_grant & {NUM_CH{reset_l}};
   assign w_fire     = |ack;
   assign w_sel_addr = w_ch_addr[w_gidx];
   assign w_sel_data = w_ch_data[w_gidx];
   assign w_rd_fire  = w_fire & rh_wl[w_gidx];
   assign w_wr_fire  = w_fire & ~rh_wl[w_gidx];

   // Storage and its read register carry no reset so they map onto block RAM.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_q;

   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[w_sel_addr] <= w_sel_data;
      if (w_rd_fire) r_rd_q <= r_mem[w_sel_addr];
   end

   logic [NUM_CH-1:0]     r_vld1;
   logic                  r_have;
   logic [DATA_WIDTH-1:0] w_data1;

   // r_have masks the unreset RAM register so data_r reads zero until the first read after reset.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_vld1 <= '0;
         r_have <= 1'b0;
      end else begin
         r_vld1 <= ack & rh_wl;
         if (w_rd_fire) r_have <= 1'b1;
      end
   end

   assign w_data1 = r_have ? r_rd_q : '0;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] r_data2;
         logic [NUM_CH-1:0]     r_vld2;

         always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
               r_data2 <= '0;
               r_vld2  <= '0;
            end else begin
               r_vld2 <= r_vld1;
               if (|r_vld1) r_data2 <= w_data1;
            end
         end

         assign data_r    = r_data2;
         assign data_r_en = r_vld2;
      end else begin : g_no_out_reg
         assign data_r    = w_data1;
         assign data_r_en = r_vld1;
      end
   endgenerate

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Self-checking bench for bram_arb_ctrl: vector table plus hand sequences, reads scored via a queue.
// Expectations adapt to BRAM_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_bram_arb_ctrl;

   localparam int AW   = 14;
   localparam int DW   = 8;
   localparam int NCH  = 2;
   localparam int OREG = 0;

`ifdef BRAM_ARB_FIXED_PRIO_EN
   localparam logic [1:0] ALT = 2'b01;
`else
   localparam logic [1:0] ALT = 2'b10;
`endif

   logic            clk = 1'b0;
   logic            reset_l;
   logic [NCH-1:0]  req;
   logic [NCH-1:0]  rh_wl;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] data_w;
   logic [NCH-1:0]  ack;
   logic [DW-1:0]   data_r;
   logic [NCH-1:0]  data_r_en;

   always #5 clk = ~clk;

   bram_arb_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_CH     (NCH),
      .OUT_REG    (OREG)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .req       (req),
      .rh_wl     (rh_wl),
      .addr      (addr),
      .data_w    (data_w),
      .ack       (ack),
      .data_r    (data_r),
      .data_r_en (data_r_en)
   );

   typedef struct {
      logic [1:0] tag;
      logic [7:0] data;
      int         due;
   } exp_t;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  rw;
      logic [13:0] a0;
      logic [13:0] a1;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [1:0]  ack;
   } vec_t;

   exp_t       sbq [$];
   logic [7:0] model [int];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [7:0] last_data = 8'h00;
   exp_t       mon_e;

   // Output monitor: samples 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      cyc++;
      if (!reset_l) begin
         total++;
         if (data_r_en !== 2'b00 || data_r !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: en=%b data=%h want en=00 data=00", data_r_en, data_r);
         end
         last_data = 8'h00;
      end else begin
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            mon_e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL read_missing: due cycle %0d tag=%b data=%h never seen", mon_e.due, mon_e.tag, mon_e.data);
         end
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            mon_e = sbq.pop_front();
            total++;
            if (data_r_en !== mon_e.tag || data_r !== mon_e.data) begin
               bad++;
               $display("FAIL read_data: cyc=%0d en=%b data=%h want en=%b data=%h",
                        cyc, data_r_en, data_r, mon_e.tag, mon_e.data);
            end else begin
               $display("rd  cyc=%0d en=%b data=%h", cyc, data_r_en, data_r);
            end
            last_data = mon_e.data;
         end else begin
            total++;
            if (data_r_en !== 2'b00) begin
               bad++;
               $display("FAIL spurious_en: cyc=%0d en=%b want 00", cyc, data_r_en);
            end else if (data_r !== last_data) begin
               bad++;
               $display("FAIL data_hold: cyc=%0d data=%h want %h", cyc, data_r, last_data);
            end
         end
      end
   end

   task automatic drive(input logic [1:0] r, input logic [1:0] rw,
                        input logic [13:0] a0, input logic [13:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] ea, input string nm);
      int          g;
      logic [13:0] ga;
      exp_t        e;
      @(negedge clk);
      req    = r;
      rh_wl  = rw;
      addr   = {a1, a0};
      data_w = {d1, d0};
      #1;
      total++;
      if (ack !== ea) begin
         bad++;
         $display("FAIL %s: ack=%b want %b", nm, ack, ea);
      end else begin
         $display("txn %s: req=%b rw=%b ack=%b", nm, r, rw, ack);
      end
      if (ea != 2'b00) begin
         g  = ea[1] ? 1 : 0;
         ga = (g == 1) ? a1 : a0;
         if (rw[g]) begin
            e.tag  = ea;
            e.data = model.exists(int'(ga)) ? model[int'(ga)] : 8'hxx;
            e.due  = cyc + 1 + OREG;
            sbq.push_back(e);
         end else begin
            model[int'(ga)] = (g == 1) ? d1 : d0;
         end
      end
   endtask

   vec_t vt [15];

   initial begin
      vt[0]  = '{2'b11, 2'b00, 14'h0100, 14'h0200, 8'h10, 8'h20, 2'b01};
      vt[1]  = '{2'b11, 2'b00, 14'h0101, 14'h0201, 8'h11, 8'h21, ALT};
      vt[2]  = '{2'b11, 2'b00, 14'h0102, 14'h0202, 8'h12, 8'h22, 2'b01};
      vt[3]  = '{2'b11, 2'b00, 14'h0103, 14'h0203, 8'h13, 8'h23, ALT};
      vt[4]  = '{2'b01, 2'b00, 14'h0010, 14'h0000, 8'hA5, 8'h00, 2'b01};
      vt[5]  = '{2'b01, 2'b01, 14'h0010, 14'h0000, 8'h00, 8'h00, 2'b01};
      vt[6]  = '{2'b10, 2'b00, 14'h0000, 14'h3FFF, 8'h00, 8'h3C, 2'b10};
      vt[7]  = '{2'b01, 2'b01, 14'h3FFF, 14'h0000, 8'h00, 8'h00, 2'b01};
      vt[8]  = '{2'b11, 2'b11, 14'h0100, 14'h0201, 8'h00, 8'h00, ALT};
      vt[9]  = '{2'b11, 2'b11, 14'h0102, 14'h0203, 8'h00, 8'h00, 2'b01};
      vt[10] = '{2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00};
      vt[11] = '{2'b10, 2'b10, 14'h0000, 14'h0010, 8'h00, 8'h00, 2'b10};
      vt[12] = '{2'b11, 2'b01, 14'h3FFF, 14'h3FFF, 8'h00, 8'h55, 2'b01};
      vt[13] = '{2'b11, 2'b10, 14'h3FFF, 14'h3FFF, 8'h66, 8'h00, ALT};
      vt[14] = '{2'b01, 2'b01, 14'h3FFF, 14'h0000, 8'h00, 8'h00, 2'b01};

      reset_l = 1'b0;
      req     = '0;
      rh_wl   = '0;
      addr    = '0;
      data_w  = '0;

      // Requests during reset must be ignored.
      drive(2'b11, 2'b00, 14'h0010, 14'h0010, 8'h77, 8'h88, 2'b00, "reset_ack");
      @(negedge clk);
      req     = '0;
      reset_l = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].req, vt[i].rw, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1, vt[i].ack,
               $sformatf("vec%0d", i));
      end
      drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, "idle");

      // Read in flight dropped by a reset pulse; writes suppressed; pointer back to ch0.
      drive(2'b10, 2'b10, 14'h0000, 14'h3FFF, 8'h00, 8'h00, 2'b10, "rd_before_rst");
      @(posedge clk);
      #1;
      reset_l = 1'b0;
      sbq.delete();
      drive(2'b11, 2'b00, 14'h0010, 14'h0010, 8'h77, 8'h88, 2'b00, "wr_in_rst");
      @(negedge clk);
      req     = '0;
      reset_l = 1'b1;
      drive(2'b11, 2'b11, 14'h0010, 14'h0010, 8'h00, 8'h00, 2'b01, "first_after_rst");
      drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, "idle");

      for (int i = 0; i < 16; i++) begin
         drive(2'b01, 2'b00, 14'(i), 14'h0, 8'(i) ^ 8'hFF, 8'h00, 2'b01, $sformatf("fill%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         drive(2'b01 << (i % 2), 2'b11, 14'(i), 14'(i), 8'h00, 8'h00, 2'b01 << (i % 2),
               $sformatf("b2b%0d", i));
      end
      drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, "idle");

      repeat (4) @(posedge clk);
      #3;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d reads outstanding want 0", sbq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
